// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-port ALU arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_arb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_OPW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_PASB = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;

endpackage

// File: rtl/rr_pick.sv
// Two-way winner selection: one-hot grant from requests and last-served pointer.
// Latency: combinational.
// Backpressure: none; a tie goes to the port not served last.
module rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU; ALU_ARB_FIXED_PRIO_EN makes port 0 win ties.
// Latency: req in cycle N -> gnt N+1..N+2, done/result in N+2; one operation per 3 cycles.
// Backpressure: requesters hold req and operands until their done pulse.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int OPW   = DEF_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    state_t     state, state_nxt;
    logic [1:0] win;
    logic       last;
    logic       load_op, load_res, clr;

    rr_pick u_pick (
        .req  ({req1, req0}),
        .last (last),
        .win  (win)
    );

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Pretending port 1 was always served last makes every tie go to port 0.
    assign last = 1'b1;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (load_op) begin
            last <= win[1];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_op   = 1'b0;
        load_res  = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt = EXEC;
                    load_op   = 1'b1;
                end
            end
            EXEC: begin
                state_nxt = DONE;
                load_res  = 1'b1;
            end
            DONE: begin
                state_nxt = IDLE;
                clr       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // done mirrors the grant so it can only ever pulse for the owning port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            done0  <= 1'b0;
            done1  <= 1'b0;
            result <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
        end else begin
            if (load_op) begin
                gnt0   <= win[0];
                gnt1   <= win[1];
                alu_a  <= win[1] ? a1  : a0;
                alu_b  <= win[1] ? b1  : b0;
                alu_op <= win[1] ? op1 : op0;
            end
            if (load_res) begin
                result <= alu_result;
                done0  <= gnt0;
                done1  <= gnt1;
            end
            if (clr) begin
                gnt0  <= 1'b0;
                gnt1  <= 1'b0;
                done0 <= 1'b0;
                done1 <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter OPW, default 4, ALU opcode width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  port-0 request; held with operands until done0.
REQ-006 a0, b0  input  WIDTH  port-0 operands.
REQ-007 op0  input  OPW  port-0 ALU opcode.
REQ-008 req1, a1, b1, op1  input  1/WIDTH/WIDTH/OPW  port-1 equivalents.
REQ-009 gnt0, gnt1  output  1  port owns ALU; registered.
REQ-010 done0, done1  output  1  one-cycle pulse: result valid for that port.
REQ-011 result  output  WIDTH  registered result of the last completed operation.
REQ-012 alu_a, alu_b  output  WIDTH  operands to the shared ALU, driven from internal registers.
REQ-013 alu_op  output  OPW  opcode to the shared ALU, driven from internal register.
REQ-014 alu_result  input  WIDTH  combinational result returned by the shared ALU.

Function
REQ-015 FSM states: IDLE, EXEC, DONE; transitions IDLE->EXEC (any req high), EXEC->DONE (unconditional), DONE->IDLE (unconditional).
REQ-016 In IDLE with a request, the winner's a/b/op SHALL be latched into alu_a/alu_b/alu_op and its gnt set at the same edge.
REQ-017 In EXEC, alu_result SHALL be captured into result and the winner's done set at the EXEC->DONE edge.
REQ-018 Latency: req sampled in cycle N -> gnt high cycles N+1..N+2, done pulse and new result in cycle N+2; one operation per 3 cycles.
REQ-019 gnt0 and gnt1 SHALL never be high simultaneously; done SHALL only be high for the granted port and only in DONE.
REQ-020 Both req high in IDLE: round-robin; grant the port not served last; last-served pointer updates on grant.
REQ-021 Single req high: that port wins regardless of pointer.
REQ-022 Requester dropping req during EXEC: operation completes, result captured, done still pulses.
REQ-023 Req still high in the IDLE cycle following DONE is a new request (requester deasserts on done).
REQ-024 result, alu_a, alu_b, alu_op SHALL hold their values when not being loaded.
REQ-025 Operands and opcode are passed unmodified at WIDTH/OPW bits; no width conversion or opcode validation.

Reset
REQ-026 rst high SHALL immediately force IDLE, gnt0=gnt1=0, done0=done1=0, result=0, alu_a=alu_b=0, alu_op=0, pointer=port 1 served last (port 0 wins first tie).
REQ-027 Reset during EXEC or DONE SHALL abort the operation with no done pulse, and result SHALL remain 0 after release.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: port 0 SHALL always win ties and the pointer is removed; undefined: round-robin per REQ-020.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the state enumeration, default WIDTH/OPW constants, and the ALU opcode localparams (ADD=0000, SUB=0001, SLT=0010, ... LUI=1011).
REQ-030 Sub-module rr_pick SHALL implement the 2-way winner selection (reqs, pointer -> one-hot winner); the ALU itself is external.

Verification
REQ-031 req0=1, a0=5, b0=3, op0=0000; req1=0 -> gnt0 cycles 1-2, done0 in cycle 2, result=8, done1 never high.
REQ-032 req0=req1=1 held through two operations after reset (op0 ADD 1+1, op1 SUB 9-4) -> port 0 first result=2, then port 1 result=5; repeated with ALU_ARB_FIXED_PRIO_EN -> port 0 served twice.
REQ-033 req1 pulsed one cycle in IDLE with a1=0xFFFFFFFF, b1=1, op1=0000, then dropped -> operation completes, done1 pulses, result=0x00000000.
REQ-034 rst asserted mid-EXEC of port-0 operation -> all outputs 0 same cycle, no done0 after release, next request serviced normally.
REQ-035 Continuous req0 and req1 for 12 cycles -> exactly 4 done pulses alternating 0,1,0,1, gnt never both high.
